oam_dma: RTL and testbench

- OAM DMA engine, upstream master of the memory model.
- Snoops CPU writes for the DMA source register at 0xFF46, then copies OAM_LEN bytes from {page,0x00} to OAM_BASE, one byte per byte slot.
- Drives the memory read/write ports directly.
- dma_active steers the top-level mux that selects between the CPU and this block on those ports.

---
 rtl/sm83_pkg.sv | 11 +
 rtl/oam_dma.sv | 105 ++++++++++
 tb/tb_oam_dma.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sm83_pkg.sv
// Shared SM83 types and memory-map constants; this slice carries the OAM DMA additions.
package sm83_pkg;
  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  localparam addr_t DMA_REG_ADDR = 16'hFF46;
  localparam addr_t OAM_BASE     = 16'hFE00;
  localparam int    OAM_LEN      = 160;

  typedef enum logic [1:0] {DMA_IDLE, DMA_STARTUP, DMA_XFER} dma_state_t;
endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: snoops the source-page register write, then copies OAM_LEN bytes
// into OAM, one byte per T_PER_BYTE-clock slot, driving the memory ports directly.
module oam_dma #(
  parameter int              T_PER_BYTE   = 4,
  parameter sm83_pkg::addr_t OAM_BASE     = sm83_pkg::OAM_BASE,
  parameter int              OAM_LEN      = sm83_pkg::OAM_LEN,
  parameter sm83_pkg::addr_t DMA_REG_ADDR = sm83_pkg::DMA_REG_ADDR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_wen,
  input  sm83_pkg::addr_t cpu_addr,
  input  sm83_pkg::data_t cpu_w_data,
  output sm83_pkg::data_t dma_reg,
  output sm83_pkg::addr_t mem_r_addr,
  input  sm83_pkg::data_t mem_r_data,
  output sm83_pkg::addr_t mem_w_addr,
  output sm83_pkg::data_t mem_w_data,
  output logic            mem_wen,
  output logic            dma_active
);
  import sm83_pkg::*;

  localparam int PW = $clog2(T_PER_BYTE);
  localparam logic [PW-1:0] PH_LAST  = PW'(T_PER_BYTE - 1);
  localparam logic [7:0]    IDX_LAST = 8'(OAM_LEN - 1);

  dma_state_t    state, state_nxt;
  logic [PW-1:0] phase, phase_nxt;
  logic [7:0]    idx, idx_nxt;
  data_t         src_page, rd_buf;
  logic          trig;

  assign trig = cpu_wen && (cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DMA_IDLE;
      phase    <= '0;
      idx      <= '0;
      rd_buf   <= '0;
      src_page <= '0;
      dma_reg  <= 8'hFF;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      idx   <= idx_nxt;
      if (state == DMA_XFER && phase == '0)
        rd_buf <= mem_r_data;
      if (trig) begin
        dma_reg <= cpu_w_data;
        // Echo-RAM pages E0-FF alias C0-DF; the readback keeps the raw value.
        src_page <= (cpu_w_data >= 8'hE0) ? cpu_w_data - 8'h20 : cpu_w_data;
      end
    end
  end

  // Outputs come only from registered state; trig only steers the next state.
  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    idx_nxt    = idx;
    dma_active = 1'b0;
    mem_wen    = 1'b0;
    mem_r_addr = '0;
    mem_w_addr = '0;
    mem_w_data = '0;
    case (state)
      DMA_STARTUP: begin
        dma_active = 1'b1;
        if (phase == PH_LAST) begin
          phase_nxt = '0;
          state_nxt = DMA_XFER;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      DMA_XFER: begin
        dma_active = 1'b1;
        if (phase == '0)
          mem_r_addr = {src_page, idx};
        if (phase == PH_LAST) begin
          mem_wen    = 1'b1;
          mem_w_addr = OAM_BASE + {8'h00, idx};
          mem_w_data = rd_buf;
          phase_nxt  = '0;
          if (idx == IDX_LAST) begin
            state_nxt = DMA_IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 8'd1;
          end
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      default: ;
    endcase
    if (trig) begin
      state_nxt = DMA_STARTUP;
      phase_nxt = '0;
      idx_nxt   = '0;
    end
  end
endmodule

// File: tb/tb_oam_dma.sv
// Randomized bench for oam_dma: a timeline model derived from the trigger cycle
// predicts every output each cycle, with literal checks pinning key timings.
module tb_oam_dma;
  localparam int T   = 4;
  localparam int LEN = 160;
  localparam logic [15:0] BASE = 16'hFE00;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cpu_wen = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_w_data = '0;
  logic [7:0]  dma_reg, mem_r_data, mem_w_data;
  logic [15:0] mem_r_addr, mem_w_addr;
  logic        mem_wen, dma_active;

  logic [7:0] mem [0:65535];
  int errors = 0, checks = 0;
  int wen_cnt = 0, act_cnt = 0;

  // timeline model
  int        cyc = 0, trig_e = 0;
  bit        mvalid = 1'b0;
  logic [7:0] mpage = '0, mreg = 8'hFF;

  oam_dma dut (
    .clk(clk), .rst(rst), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_w_data(cpu_w_data),
    .dma_reg(dma_reg), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
    .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data), .mem_wen(mem_wen), .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  assign mem_r_data = mem[mem_r_addr];
  always @(posedge clk) if (mem_wen) mem[mem_w_addr] = mem_w_data;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, a, e, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mvalid = 1'b0;
      mreg   = 8'hFF;
    end else begin
      cyc++;
      if (cpu_wen && cpu_addr == 16'hFF46) begin
        trig_e = cyc;
        mvalid = 1'b1;
        mreg   = cpu_w_data;
        mpage  = (cpu_w_data >= 8'hE0) ? cpu_w_data - 8'h20 : cpu_w_data;
      end
    end
  end

  // n = clock number counted from the trigger edge (first clock after it is 1)
  always @(negedge clk) begin
    int n, k;
    bit act, wr, rd;
    if (!rst) begin
      n   = cyc - trig_e + 1;
      act = mvalid && n >= 1 && n <= T*(LEN+1);
      wr  = act && n >= 2*T && (n % T) == 0;
      rd  = act && n >= T+1 && ((n-1) % T) == 0 && n <= T*LEN+1;
      chk("dma_active", {31'b0, dma_active}, {31'b0, act});
      chk("mem_wen", {31'b0, mem_wen}, {31'b0, wr});
      if (wr) begin
        k = n/T - 2;
        chk("w_addr", {16'b0, mem_w_addr}, {16'b0, BASE + 16'(k)});
        chk("w_data", {24'b0, mem_w_data}, {24'b0, mem[{mpage, 8'(k)}]});
      end
      if (rd) begin
        k = (n-1)/T - 1;
        chk("r_addr", {16'b0, mem_r_addr}, {16'b0, mpage, 8'(k)});
      end
      chk("dma_reg", {24'b0, dma_reg}, {24'b0, mreg});
      if (mem_wen) wen_cnt++;
      if (dma_active) act_cnt++;
    end
  end

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_wen = 1'b1; cpu_addr = a; cpu_w_data = d;
    @(negedge clk);
    cpu_wen = 1'b0;
  endtask

  task automatic wait_idle();
    int i = 0;
    while (dma_active && i < 3000) begin
      @(negedge clk);
      i++;
    end
    chk("idle_timeout", {31'b0, dma_active}, 32'd0);
  endtask

  task automatic chk_oam(input logic [7:0] page);
    for (int k = 0; k < LEN; k++)
      chk("oam", {24'b0, mem[BASE + 16'(k)]}, {24'b0, mem[{page, 8'(k)}]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = (a >= 16'hFE00) ? 8'h00 : 8'($urandom);
    #13;
    chk("rst_active", {31'b0, dma_active}, 32'd0);
    chk("rst_wen", {31'b0, mem_wen}, 32'd0);
    chk("rst_dma_reg", {24'b0, dma_reg}, 32'h0000_00FF);
    chk("rst_r_addr", {16'b0, mem_r_addr}, 32'd0);
    chk("rst_w_addr", {16'b0, mem_w_addr}, 32'd0);
    chk("rst_w_data", {24'b0, mem_w_data}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // ignored writes
    act_cnt = 0;
    cpu_wr(16'hFF45, 8'h12);
    cpu_wr(16'hFF47, 8'h34);
    repeat (10) @(negedge clk);
    chk("ign_dma_reg", {24'b0, dma_reg}, 32'h0000_00FF);
    chk("ign_active_cnt", act_cnt, 32'd0);

    // basic copy
    for (int k = 0; k < LEN; k++) mem[16'hC000 + 16'(k)] = 8'(k) ^ 8'h5A;
    wen_cnt = 0; act_cnt = 0;
    cpu_wr(16'hFF46, 8'hC0);
    wait_idle();
    chk("basic_wen_cnt", wen_cnt, 32'd160);
    chk("basic_act_cnt", act_cnt, 32'd644);
    for (int k = 0; k < LEN; k++)
      chk("basic_oam", {24'b0, mem[BASE + 16'(k)]}, {24'b0, 8'(k) ^ 8'h5A});

    // cycle timing
    cpu_wr(16'hFF46, 8'h80);
    repeat (4) @(negedge clk);
    chk("t5_r_addr", {16'b0, mem_r_addr}, 32'h8000);
    repeat (3) @(negedge clk);
    chk("t8_wen", {31'b0, mem_wen}, 32'd1);
    chk("t8_w_addr", {16'b0, mem_w_addr}, 32'hFE00);
    repeat (636) @(negedge clk);
    chk("t644_wen", {31'b0, mem_wen}, 32'd1);
    chk("t644_w_addr", {16'b0, mem_w_addr}, 32'hFE9F);
    @(negedge clk);
    chk("t645_active", {31'b0, dma_active}, 32'd0);

    // echo-page remap
    cpu_wr(16'hFF46, 8'hE1);
    repeat (4) @(negedge clk);
    chk("remap_r_addr", {16'b0, mem_r_addr}, 32'hC100);
    wait_idle();
    chk("remap_dma_reg", {24'b0, dma_reg}, 32'h0000_00E1);
    chk_oam(8'hC1);

    // restart at E+100
    wen_cnt = 0;
    cpu_wr(16'hFF46, 8'hC0);
    repeat (98) @(negedge clk);
    cpu_wr(16'hFF46, 8'hD0);
    repeat (3) @(negedge clk);
    chk("rs_startup_wen", {31'b0, mem_wen}, 32'd0);
    chk("rs_startup_act", {31'b0, dma_active}, 32'd1);
    @(negedge clk);
    chk("rs_r_addr", {16'b0, mem_r_addr}, 32'hD000);
    wait_idle();
    chk("rs_wen_cnt", wen_cnt, 32'd184);
    chk_oam(8'hD0);

    // async reset mid-transfer
    cpu_wr(16'hFF46, 8'hC0);
    repeat (299) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_active", {31'b0, dma_active}, 32'd0);
    chk("ar_wen", {31'b0, mem_wen}, 32'd0);
    chk("ar_dma_reg", {24'b0, dma_reg}, 32'h0000_00FF);
    wen_cnt = 0;
    @(negedge clk); #2 rst = 1'b0;
    repeat (700) @(negedge clk);
    chk("ar_no_writes", wen_cnt, 32'd0);

    // randomized transfers, restarts and stray writes
    for (int it = 0; it < 8; it++) begin
      logic [7:0] pg;
      int gap;
      pg = 8'($urandom);
      cpu_wr(16'hFF46, pg);
      for (int j = 0; j < 4; j++) begin
        logic [15:0] a;
        a = ($urandom_range(0, 1) == 0) ? 16'hFF45 + 16'(2 * $urandom_range(0, 1)) : 16'($urandom);
        if (a == 16'hFF46) a = 16'hFF47;
        repeat ($urandom_range(1, 60)) @(negedge clk);
        cpu_wr(a, 8'($urandom));
      end
      if ($urandom_range(0, 1) == 1) begin
        gap = $urandom_range(1, 400);
        repeat (gap) @(negedge clk);
        pg = 8'($urandom);
        cpu_wr(16'hFF46, pg);
      end
      wait_idle();
      chk_oam((pg >= 8'hE0) ? pg - 8'h20 : pg);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
